// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-side arbiter family.
// Latency: none (declarations only).
// Backpressure: n/a.
package fifo_arb_pkg;

  // Arbiter FSM states: arbitrating, or a producer currently holds the write port
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Default parameter values shared by the arbiter and its picker
  localparam int DEF_NREQ   = 4;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_BURST  = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin search: first asserted request at or after ptr, modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; caller decides whether to act on the pick.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  logic [ID_W-1:0] cand;

  // Walk ptr, ptr+1, ... wrapping at NREQ; keep the first hit
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers.
// Latency: one cycle from valid in IDLE to first beat; beats then pass through combinationally.
// Backpressure: fifo_alm_full blocks new grants; fifo_full stalls the active burst (req_ready low).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ   = DEF_NREQ,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int BURST  = DEF_BURST,
  localparam int ID_W   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  input  logic                   fifo_alm_full,
  output logic                   fifo_wren,
  output logic [DATA_W-1:0]      fifo_wrdata,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy
);

  localparam int CNT_W = $clog2(BURST + 1);

  arb_state_e      state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] grant_id_q;
  logic [CNT_W-1:0] beat_cnt_q;

  logic [ID_W-1:0]   rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_d;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              in_burst;
  logic              gnt_vld;
  logic              beat;
  logic              last_beat;
  logic [DATA_W-1:0] sel_data;

  rr_picker #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign in_burst = (state_q == ARB_BURST);
  assign gnt_vld  = req_valid[grant_id_q];
  // A reset cycle never counts as a handshake, even if the FSM still shows BURST
  assign beat      = in_burst && !rstn && gnt_vld && !fifo_full;
  assign last_beat = (beat_cnt_q == CNT_W'(BURST - 1));

  // Pointer moves just past the producer whose burst is ending
  assign rr_ptr_d   = (grant_id_q == ID_W'(NREQ - 1)) ? '0 : grant_id_q + ID_W'(1);
  assign beat_cnt_d = beat_cnt_q + CNT_W'(1);

  // Data mux: select the granted producer's lane
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id_q == ID_W'(k)) begin
        sel_data = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Handshake outputs: only the granted producer may see ready, and only when the FIFO has room
  always_comb begin
    req_ready   = '0;
    fifo_wren   = 1'b0;
    fifo_wrdata = '0;
    if (in_burst) begin
      fifo_wrdata = sel_data;
      if (!rstn) begin
        req_ready[grant_id_q] = !fifo_full;
        fifo_wren             = beat;
      end
    end
  end

  // Arbitration FSM: grant in IDLE, count beats in BURST, rotate pointer on every burst end
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found && !fifo_alm_full) begin
            state_q    <= ARB_BURST;
            grant_id_q <= pick_idx;
            beat_cnt_q <= '0;
          end
        end
        ARB_BURST: begin
          if (!gnt_vld) begin
            // Producer went away; give up the port without a beat
            state_q  <= ARB_IDLE;
            rr_ptr_q <= rr_ptr_d;
          end else if (beat) begin
            if (last_beat) begin
              state_q  <= ARB_IDLE;
              rr_ptr_q <= rr_ptr_d;
            end else begin
              beat_cnt_q <= beat_cnt_d;
            end
          end
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = in_burst;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus multi-cycle sequences.
// Latency: inputs driven 1ns after posedge, outputs sampled at negedge.
// Backpressure: fifo_full / fifo_alm_full driven directly by the vectors.
module tb_fifo_wr_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 128;
  localparam int BURST  = 4;
  localparam int NVEC   = 33;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   fifo_full;
  logic                   fifo_alm_full;
  logic                   fifo_wren;
  logic [DATA_W-1:0]      fifo_wrdata;
  logic [1:0]             grant_id;
  logic                   busy;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] wq[$];
  int nwr;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic       full;
    logic       afull;
    logic       busy;
    logic [3:0] rdy;
    logic       wren;
    logic [1:0] gid;
    logic [7:0] wdat;
  } vec_t;

  vec_t tv[NVEC];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NREQ   (NREQ),
    .DATA_W (DATA_W),
    .BURST  (BURST)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_alm_full (fifo_alm_full),
    .fifo_wren     (fifo_wren),
    .fifo_wrdata   (fifo_wrdata),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [127:0] d);
    req_data[k*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    rstn          = 1'b1;
    req_valid     = '0;
    fifo_full     = 1'b0;
    fifo_alm_full = 1'b0;
    req_data      = '0;
    for (int k = 0; k < NREQ; k++) set_data(k, 128'(8'hD0 + k));

    //            rst   vld     full  afull busy  rdy     wren  gid    wdat
    tv[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    // almost-full holds producer 3 off
    tv[1]  = '{1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    tv[2]  = '{1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    tv[3]  = '{1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    tv[4]  = '{1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3};
    // full stall for three cycles
    tv[5]  = '{1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, 8'hD3};
    tv[6]  = '{1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, 8'hD3};
    tv[7]  = '{1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, 8'hD3};
    tv[8]  = '{1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3};
    // valid drop ends burst, rr_ptr -> 0
    tv[9]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 2'd3, 8'hD3};
    tv[10] = '{1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 8'h00};
    tv[11] = '{1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 8'h00};
    // full 4-beat burst for producer 1; almost-full mid-burst is ignored
    tv[12] = '{1'b0, 4'b0110, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hD1};
    tv[13] = '{1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hD1};
    tv[14] = '{1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hD1};
    tv[15] = '{1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hD1};
    tv[16] = '{1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 8'h00};
    tv[17] = '{1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hD2};
    tv[18] = '{1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hD2};
    // reset mid-burst: no beat in the reset cycle
    tv[19] = '{1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hD2};
    tv[20] = '{1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    tv[21] = '{1'b0, 4'b0111, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hD0};
    tv[22] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, 8'hD0};
    // one beat from producer 2 to move rr_ptr to 3
    tv[23] = '{1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    tv[24] = '{1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hD2};
    tv[25] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 2'd2, 8'hD2};
    // wrap: ptr=3, producers 0 and 3 valid -> 3 then 0
    tv[26] = '{1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h00};
    tv[27] = '{1'b0, 4'b1001, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3};
    tv[28] = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 2'd3, 8'hD3};
    tv[29] = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 8'h00};
    tv[30] = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hD0};
    tv[31] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, 8'hD0};
    tv[32] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};

    tick();
    tick();

    // ---- vector table ----
    for (int i = 0; i < NVEC; i++) begin
      rstn          = tv[i].rst;
      req_valid     = tv[i].vld;
      fifo_full     = tv[i].full;
      fifo_alm_full = tv[i].afull;
      @(negedge clk);
      chk($sformatf("v%0d_busy", i), 128'(busy), 128'(tv[i].busy));
      chk($sformatf("v%0d_ready", i), 128'(req_ready), 128'(tv[i].rdy));
      chk($sformatf("v%0d_wren", i), 128'(fifo_wren), 128'(tv[i].wren));
      chk($sformatf("v%0d_gid", i), 128'(grant_id), 128'(tv[i].gid));
      chk($sformatf("v%0d_wdata", i), fifo_wrdata, 128'(tv[i].wdat));
      tick();
    end

    // ---- round robin: all valid, no backpressure ----
    rstn      = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    fifo_alm_full = 1'b0;
    tick();
    rstn      = 1'b0;
    req_valid = 4'hF;
    nwr       = 0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (c % 5 == 0) begin
        chk($sformatf("rr_c%0d_busy", c), 128'(busy), 128'(0));
        chk($sformatf("rr_c%0d_wren", c), 128'(fifo_wren), 128'(0));
      end else begin
        chk($sformatf("rr_c%0d_wren", c), 128'(fifo_wren), 128'(1));
        chk($sformatf("rr_c%0d_gid", c), 128'(grant_id), 128'((c / 5) % 4));
        chk($sformatf("rr_c%0d_wdata", c), fifo_wrdata, 128'(8'hD0 + (c / 5) % 4));
      end
      if (c < 20 && fifo_wren) nwr++;
      tick();
    end
    chk("rr_writes_in_20", 128'(nwr), 128'(16));
    req_valid = '0;
    tick();
    tick();

    // ---- short burst from producer 1: A1, A2, then drop ----
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    wq.delete();
    set_data(1, 128'hA1);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("sb_idle_busy", 128'(busy), 128'(0));
    tick();
    @(negedge clk);
    if (fifo_wren) wq.push_back(fifo_wrdata);
    tick();
    set_data(1, 128'hA2);
    @(negedge clk);
    if (fifo_wren) wq.push_back(fifo_wrdata);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    if (fifo_wren) wq.push_back(fifo_wrdata);
    chk("sb_drop_busy", 128'(busy), 128'(1));
    chk("sb_drop_wren", 128'(fifo_wren), 128'(0));
    tick();
    req_valid = 4'b1111;
    @(negedge clk);
    chk("sb_back_idle", 128'(busy), 128'(0));
    chk("sb_nwords", 128'(wq.size()), 128'(2));
    if (wq.size() == 2) begin
      chk("sb_word0", wq[0], 128'hA1);
      chk("sb_word1", wq[1], 128'hA2);
    end
    tick();
    @(negedge clk);
    chk("sb_next_grant_ptr2", 128'(grant_id), 128'(2));
    req_valid = '0;
    tick();
    tick();
    set_data(1, 128'hD1);

    // ---- full stall after beat 1 keeps data order ----
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    wq.delete();
    set_data(0, 128'hB0);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("fs_idle_busy", 128'(busy), 128'(0));
    tick();
    @(negedge clk);
    if (fifo_wren) wq.push_back(fifo_wrdata);
    tick();
    set_data(0, 128'hB1);
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("fs_stall%0d_wren", s), 128'(fifo_wren), 128'(0));
      chk($sformatf("fs_stall%0d_ready", s), 128'(req_ready), 128'(0));
      chk($sformatf("fs_stall%0d_busy", s), 128'(busy), 128'(1));
      tick();
    end
    fifo_full = 1'b0;
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      if (fifo_wren) wq.push_back(fifo_wrdata);
      tick();
      set_data(0, 128'(8'hB0 + j + 1));
    end
    @(negedge clk);
    chk("fs_end_busy", 128'(busy), 128'(0));
    chk("fs_end_wren", 128'(fifo_wren), 128'(0));
    req_valid = '0;
    chk("fs_nwords", 128'(wq.size()), 128'(4));
    if (wq.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("fs_word%0d", j), wq[j], 128'(8'hB0 + j));
      end
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of `my_fifo` between `NREQ` independent producers. Each producer offers data on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `i_wren`/`i_wrdata` directly. It never starts a burst while the FIFO reports almost-full, and never writes while the FIFO reports full. It sits between the producer blocks and the FIFO, in the same clock domain.

## Interface
- `NREQ`, 4: number of producers, 2..16.
- `DATA_W`, 128: data width; must match FIFO `DATA_W`.
- `BURST`, 4: maximum beats per grant, ≥1.
- `ID_W`, `$clog2(NREQ)`: grant index width; derived, not overridden.

- `clk`  in  1  clock; all logic on rising edge.
- `rstn`  in  1  reset; synchronous, active-high (asserted = 1).
- `req_valid`  in  NREQ  per-producer data valid.
- `req_data`  in  NREQ*DATA_W  producer k occupies bits [k*DATA_W +: DATA_W].
- `req_ready`  out  NREQ  per-producer accept; one-hot or zero.
- `fifo_full`  in  1  from FIFO `o_full`.
- `fifo_alm_full`  in  1  from FIFO `o_alm_full`.
- `fifo_wren`  out  1  to FIFO `i_wren`.
- `fifo_wrdata`  out  DATA_W  to FIFO `i_wrdata`.
- `grant_id`  out  ID_W  index of the current or last granted producer.
- `busy`  out  1  high while in BURST.

## Operation
- State machine with two states:
  - IDLE: arbitrating.
  - BURST: a producer is granted.
- Registers:
  - `state`
  - `rr_ptr` (ID_W): highest-priority index.
  - `grant_id` (ID_W)
  - `beat_cnt`: width `$clog2(BURST+1)`.
- IDLE → BURST:
  - Condition: `|req_valid && !fifo_alm_full`.
  - `grant_id` ← first k with `req_valid[k]`, searching `rr_ptr`, `rr_ptr+1`, … modulo NREQ.
  - `beat_cnt` ← 0.
- In BURST, a beat occurs when `req_valid[grant_id] && !fifo_full`. Combinational outputs during BURST:
  - `req_ready[grant_id]` = `!fifo_full`.
  - `fifo_wren` = beat.
  - `fifo_wrdata` = `req_data[grant_id]`.
- BURST → IDLE occurs on either of:
  - a beat with `beat_cnt == BURST-1`;
  - `req_valid[grant_id] == 0` in any BURST cycle (no beat that cycle).
- On every BURST → IDLE transition, `rr_ptr` ← `grant_id+1`, wrapping to 0 at NREQ.
- Otherwise, each beat increments `beat_cnt`.
- Full handling:
  - `fifo_full` high in BURST: stall. State is held, no beat, `req_ready` all 0.
  - `fifo_alm_full` does not end a burst already in progress.
- In IDLE: `req_ready` = 0, `fifo_wren` = 0, `fifo_wrdata` = 0.
- Non-granted producers always see `req_ready` = 0.
- Producers must hold `req_valid`/`req_data` stable until accepted. The arbiter does not check this.
- Reset (`rstn`=1 at a rising edge): state IDLE, `rr_ptr` 0, `grant_id` 0, `beat_cnt` 0, `busy` 0. This holds even mid-burst; no beat occurs in the reset cycle.

## Timing
- Grant latency: one cycle. Valid seen in IDLE at edge N; first beat possible in cycle N+1.
- Beat throughput: one per cycle within a burst, zero added latency. FIFO write happens in the same cycle as the handshake.
- One mandatory IDLE bubble between consecutive bursts, including the same producer re-winning.
- Fairness: with all producers continuously valid and no backpressure, grants rotate 0,1,…,NREQ-1,0. Each grant is BURST beats, so each cycle is NREQ·(BURST+1) cycles.
- `fifo_full` lags FIFO occupancy by one cycle. `fifo_alm_full` gating at burst start gives margin; system integration must keep `BURST ≤ UPP_TH`.

## Structure
- Package `fifo_arb_pkg`: state enum (`ARB_IDLE`, `ARB_BURST`), default parameter constants.
- Sub-module `rr_picker`:
  - Purely combinational.
  - Inputs: `req` (NREQ), `ptr` (ID_W).
  - Outputs: `found`, `idx` (ID_W).
  - Reusable by the planned read-side scheduler.
- The top holds the FSM, counters and data mux.

## Test plan
- Reset mid-burst: grant producer 2, `rstn`=1 after 2 beats → next cycle `busy`=0, `req_ready`=0, `fifo_wren`=0; after release, producer 0 wins first.
- Round-robin: all 4 valid, BURST=4, no backpressure → grants 0,1,2,3,0. Exactly 4 beats each, one idle cycle between, 16 writes in 20 cycles.
- Short burst: producer 1 sends 2 beats (0xA1, 0xA2) then drops valid → FIFO receives exactly those 2 words. Returns to IDLE; `rr_ptr`=2.
- Full stall: `fifo_full`=1 for 3 cycles after beat 1 of a grant → no `fifo_wren`, `req_ready`=0 for 3 cycles. Burst resumes with beat 2; data order is preserved.
- Almost-full gate: `fifo_alm_full`=1 in IDLE with producer 3 valid → no grant until it drops; grant to 3 on the next edge.
- Wrap: `rr_ptr`=3, only producers 0 and 3 valid → 3 granted first, then 0.
